// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the audio fetch scheduler.
//   state_e              : scheduler states, in traversal order
//   DEFAULT_NUM_CHANNELS : default number of audio channels served
//   SAMPLE_W / ADDR_W    : sample data width and memory byte-address width
`timescale 1ns/1ps
package audio_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_REQ,
        ST_WAIT,
        ST_DELIVER
    } state_e;

    localparam int DEFAULT_NUM_CHANNELS = 8;
    localparam int SAMPLE_W             = 16;
    localparam int ADDR_W               = 32;
endpackage

// File: rtl/audio_fetch_scheduler_if.sv
// audio_fetch_scheduler_if: single-outstanding memory read bus.
//   mem_req_valid/mem_req_addr/mem_req_ready : request handshake (accept on valid & ready)
//   mem_rsp_valid/mem_rsp_data               : single-cycle read-data strobe
// Modports: master = scheduler side, slave = memory side.
`timescale 1ns/1ps
interface audio_fetch_scheduler_if;
    import audio_pkg::*;

    logic                mem_req_valid;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic                mem_req_ready;
    logic                mem_rsp_valid;
    logic [SAMPLE_W-1:0] mem_rsp_data;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/audio_fetch_scheduler.sv
// audio_fetch_scheduler: on each sample_tick walks the channels in ascending
// order, fetches one 16-bit sample for every playing channel over the memory
// bus (one request outstanding at a time) and hands it to the channel with a
// one-cycle ch_ready strobe.
// Ports:
//   clk, rst (async, active-low)
//   sample_tick           : starts one fetch round
//   ch_playing, ch_addr   : per-channel playing flag and packed 32-bit address
//   ch_ready, ch_sample   : one-hot delivery strobe and sample data
//   mem                   : memory bus (master modport)
//   busy, overrun, overrun_clr : status; overrun is sticky, set wins over clear
//   timeout               : only with AUDIO_FETCH_TIMEOUT_EN; pulses when WAIT
//                           gives up after TIMEOUT_CYCLES and delivers 0
// Optional feature macro: AUDIO_FETCH_TIMEOUT_EN
`timescale 1ns/1ps
module audio_fetch_scheduler
    import audio_pkg::*;
#(
    parameter int NUM_CHANNELS   = DEFAULT_NUM_CHANNELS,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sample_tick,
    input  logic [NUM_CHANNELS-1:0]        ch_playing,
    input  logic [NUM_CHANNELS*ADDR_W-1:0] ch_addr,
    output logic [NUM_CHANNELS-1:0]        ch_ready,
    output logic [SAMPLE_W-1:0]            ch_sample,
    audio_fetch_scheduler_if.master        mem,
    output logic                           busy,
    output logic                           overrun,
    input  logic                           overrun_clr
`ifdef AUDIO_FETCH_TIMEOUT_EN
    ,
    output logic                           timeout
`endif
);

    // One extra bit so the index can never wrap before the last-channel compare.
    localparam int IDX_W = $clog2(NUM_CHANNELS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("audio_fetch_scheduler: NUM_CHANNELS must be 1..16 and TIMEOUT_CYCLES >= 1");
    end

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [SAMPLE_W-1:0]   data_q, data_d;
    logic [NUM_CHANNELS-1:0] ch_ready_q, ch_ready_d;
    logic                  req_valid_q, req_valid_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;

`ifdef AUDIO_FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    // Channel mux: playing flag, address and one-hot strobe for the current index.
    logic                    sel_playing;
    logic [ADDR_W-1:0]       sel_addr;
    logic [NUM_CHANNELS-1:0] sel_onehot;

    always_comb begin
        sel_playing = 1'b0;
        sel_addr    = '0;
        sel_onehot  = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_playing   = ch_playing[i];
                sel_addr      = ch_addr[i*ADDR_W +: ADDR_W];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        data_d      = data_q;
        ch_ready_d  = '0;
        req_valid_d = req_valid_q;
`ifdef AUDIO_FETCH_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    idx_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (sel_playing) begin
                    addr_d      = sel_addr;
                    req_valid_d = 1'b1;
                    state_d     = ST_REQ;
                end else if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_REQ: begin
                if (mem.mem_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = ST_WAIT;
`ifdef AUDIO_FETCH_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (mem.mem_rsp_valid) begin
                    data_d     = mem.mem_rsp_data;
                    ch_ready_d = sel_onehot;
                    state_d    = ST_DELIVER;
                end
`ifdef AUDIO_FETCH_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    data_d     = '0;
                    ch_ready_d = sel_onehot;
                    timeout_d  = 1'b1;
                    state_d    = ST_DELIVER;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_DELIVER: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_SCAN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);

        // A tick while a round is in flight is dropped; it only raises overrun.
        overrun_d = overrun_q;
        if (overrun_clr)
            overrun_d = 1'b0;
        if (sample_tick && (state_q != ST_IDLE))
            overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            ch_ready_q  <= '0;
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef AUDIO_FETCH_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            ch_ready_q  <= ch_ready_d;
            req_valid_q <= req_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
`ifdef AUDIO_FETCH_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign ch_ready          = ch_ready_q;
    assign ch_sample         = data_q;
    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_req_addr  = addr_q;
    assign busy              = busy_q;
    assign overrun           = overrun_q;
`ifdef AUDIO_FETCH_TIMEOUT_EN
    assign timeout           = timeout_q;
`endif

endmodule

// File: tb/tb_audio_fetch_scheduler.sv
// tb_audio_fetch_scheduler: self-checking bench for audio_fetch_scheduler.
// A memory model answers requests one cycle after acceptance with random data;
// a list-level reference model predicts request order, deliveries and round
// length from the playing mask and addresses.
// With AUDIO_FETCH_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYCLES=4.
`timescale 1ns/1ps
module tb_audio_fetch_scheduler;

    localparam int NCH = 8;
`ifdef AUDIO_FETCH_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                sample_tick = 1'b0;
    logic [NCH-1:0]      ch_playing = '0;
    logic [NCH*32-1:0]   ch_addr = '0;
    logic [NCH-1:0]      ch_ready;
    logic [15:0]         ch_sample;
    logic                busy;
    logic                overrun;
    logic                overrun_clr = 1'b0;
`ifdef AUDIO_FETCH_TIMEOUT_EN
    logic                timeout;
`endif

    audio_fetch_scheduler_if mem_if ();

    audio_fetch_scheduler #(
        .NUM_CHANNELS   (NCH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .ch_playing  (ch_playing),
        .ch_addr     (ch_addr),
        .ch_ready    (ch_ready),
        .ch_sample   (ch_sample),
        .mem         (mem_if),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
`ifdef AUDIO_FETCH_TIMEOUT_EN
        ,
        .timeout     (timeout)
`endif
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Observation logs and memory-model controls
    logic [NCH-1:0] rdy_vec_log[$];
    logic [15:0]    rdy_smp_log[$];
    logic [31:0]    req_log[$];
    logic [15:0]    rsp_log[$];
    logic [31:0]    hold_log[$];
    int  valid_cycles = 0;
    int  hold_cnt     = 0;
    int  to_cnt       = 0;
    int  to_rdy       = 0;
    bit  rsp_en       = 1'b1;
    bit  rsp_pending  = 1'b0;
    bit  late_rsp     = 1'b0;

    // Memory model + monitor; everything happens on the falling edge.
    initial begin
        mem_if.mem_req_ready = 1'b1;
        mem_if.mem_rsp_valid = 1'b0;
        mem_if.mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (ch_ready != '0) begin
                rdy_vec_log.push_back(ch_ready);
                rdy_smp_log.push_back(ch_sample);
            end
            if (mem_if.mem_req_valid) valid_cycles++;
`ifdef AUDIO_FETCH_TIMEOUT_EN
            if (timeout) begin
                to_cnt++;
                if (ch_ready != '0) to_rdy++;
            end
`endif
            mem_if.mem_rsp_valid = 1'b0;
            if (late_rsp) begin
                late_rsp = 1'b0;
                mem_if.mem_rsp_valid = 1'b1;
                mem_if.mem_rsp_data  = 16'($urandom);
                rsp_log.push_back(mem_if.mem_rsp_data);
            end else if (rsp_pending) begin
                rsp_pending = 1'b0;
                if (rsp_en) begin
                    mem_if.mem_rsp_valid = 1'b1;
                    mem_if.mem_rsp_data  = 16'($urandom);
                    rsp_log.push_back(mem_if.mem_rsp_data);
                end
            end
            if (mem_if.mem_req_valid && hold_cnt > 0) begin
                mem_if.mem_req_ready = 1'b0;
                hold_cnt--;
                hold_log.push_back(mem_if.mem_req_addr);
            end else begin
                mem_if.mem_req_ready = (hold_cnt == 0);
            end
            if (mem_if.mem_req_valid && mem_if.mem_req_ready) begin
                req_log.push_back(mem_if.mem_req_addr);
                rsp_pending = 1'b1;
            end
        end
    end

    task automatic clear_logs();
        rdy_vec_log.delete();
        rdy_smp_log.delete();
        req_log.delete();
        rsp_log.delete();
        hold_log.delete();
        valid_cycles = 0;
        to_cnt = 0;
        to_rdy = 0;
    endtask

    task automatic pulse_tick();
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
        n_vec++;
        if (cyc >= 2000) begin
            n_fail++;
            $display("FAIL %s_round_end: busy still %b after %0d cycles, required 0", tag, busy, cyc);
        end
    endtask

    // Reference model: requests for playing channels in ascending order, one
    // delivery each carrying the returned data (0 on timeout), round length
    // of 4 cycles per playing channel (3+TO when timing out) and 1 per idle one.
    task automatic check_round(input string tag, input logic [NCH-1:0] play,
                               input logic [NCH*32-1:0] addrs, input int busy_cyc,
                               input bit timed_out);
        logic [31:0] exp_req[$];
        int          exp_ch[$];
        int          exp_busy;
        logic [15:0] exp_d;
        exp_busy = 0;
        for (int i = 0; i < NCH; i++) begin
            if (play[i]) begin
                exp_req.push_back(addrs[32*i +: 32]);
                exp_ch.push_back(i);
                exp_busy += timed_out ? (3 + TO) : 4;
            end else begin
                exp_busy += 1;
            end
        end
        n_vec++;
        if (busy_cyc !== exp_busy) begin
            n_fail++;
            $display("FAIL %s_busy_cycles: got %0d required %0d", tag, busy_cyc, exp_busy);
        end
        n_vec++;
        if (req_log.size() != exp_req.size()) begin
            n_fail++;
            $display("FAIL %s_req_count: got %0d required %0d", tag, req_log.size(), exp_req.size());
        end else begin
            for (int k = 0; k < exp_req.size(); k++) begin
                n_vec++;
                if (req_log[k] !== exp_req[k]) begin
                    n_fail++;
                    $display("FAIL %s_req_addr[%0d]: got %h required %h", tag, k, req_log[k], exp_req[k]);
                end
            end
        end
        n_vec++;
        if (rdy_vec_log.size() != exp_ch.size() || (!timed_out && rsp_log.size() != exp_ch.size())) begin
            n_fail++;
            $display("FAIL %s_deliver_count: got %0d required %0d", tag, rdy_vec_log.size(), exp_ch.size());
        end else begin
            for (int k = 0; k < exp_ch.size(); k++) begin
                exp_d = timed_out ? 16'h0000 : rsp_log[k];
                n_vec++;
                if (rdy_vec_log[k] !== NCH'(1 << exp_ch[k]) || rdy_smp_log[k] !== exp_d) begin
                    n_fail++;
                    $display("FAIL %s_deliver[%0d]: got ready %b sample %h required ready %b sample %h",
                             tag, k, rdy_vec_log[k], rdy_smp_log[k], NCH'(1 << exp_ch[k]), exp_d);
                end
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || mem_if.mem_req_valid !== 1'b0 || ch_ready !== '0 ||
            overrun !== 1'b0 || ch_sample !== 16'h0 || mem_if.mem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy %b valid %b ready %b ovr %b smp %h addr %h required all 0",
                     busy, mem_if.mem_req_valid, ch_ready, overrun, ch_sample, mem_if.mem_req_addr);
        end
        repeat (3) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_tick: got busy %b required 0", busy);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        ch_playing = 8'b0010_0101;
        for (int i = 0; i < NCH; i++) ch_addr[32*i +: 32] = 32'h1000 * i;
        clear_logs();
        pulse_tick();
        wait_idle("basic", cyc);
        check_round("basic", ch_playing, ch_addr, cyc, 1'b0);
    endtask

    task automatic test_random();
        int cyc;
        for (int r = 0; r < 6; r++) begin
            ch_playing = 8'($urandom_range(0, 255));
            for (int i = 0; i < NCH; i++) ch_addr[32*i +: 32] = $urandom;
            clear_logs();
            pulse_tick();
            wait_idle("random", cyc);
            check_round("random", ch_playing, ch_addr, cyc, 1'b0);
        end
    endtask

    task automatic test_no_channel();
        int cyc;
        ch_playing = '0;
        clear_logs();
        pulse_tick();
        wait_idle("none", cyc);
        check_round("none", ch_playing, ch_addr, cyc, 1'b0);
    endtask

    task automatic test_backpressure();
        int cyc;
        int w;
        logic [31:0] orig;
        orig = $urandom;
        ch_playing = 8'b0001_0000;
        ch_addr[32*4 +: 32] = orig;
        clear_logs();
        hold_cnt = 10;
        pulse_tick();
        w = 0;
        while (hold_log.size() == 0 && w < 50) begin @(negedge clk); w++; end
        // Change the source address and stop playing once the request is out.
        ch_addr[32*4 +: 32] = ~orig;
        ch_playing = '0;
        wait_idle("bp", cyc);
        n_vec++;
        if (hold_log.size() != 10) begin
            n_fail++;
            $display("FAIL bp_stall_cycles: got %0d required 10", hold_log.size());
        end
        foreach (hold_log[k]) begin
            n_vec++;
            if (hold_log[k] !== orig) begin
                n_fail++;
                $display("FAIL bp_addr_stable[%0d]: got %h required %h", k, hold_log[k], orig);
            end
        end
        n_vec++;
        if (req_log.size() != 1 || valid_cycles != 11) begin
            n_fail++;
            $display("FAIL bp_accept: got %0d accepts %0d valid cycles required 1 and 11", req_log.size(), valid_cycles);
        end else begin
            n_vec++;
            if (req_log[0] !== orig) begin
                n_fail++;
                $display("FAIL bp_accept_addr: got %h required %h", req_log[0], orig);
            end
        end
        n_vec++;
        if (rdy_vec_log.size() != 1 || rsp_log.size() != 1) begin
            n_fail++;
            $display("FAIL bp_deliver_count: got %0d required 1", rdy_vec_log.size());
        end else if (rdy_vec_log[0] !== 8'b0001_0000 || rdy_smp_log[0] !== rsp_log[0]) begin
            n_fail++;
            $display("FAIL bp_deliver: got %b/%h required 00010000/%h", rdy_vec_log[0], rdy_smp_log[0], rsp_log[0]);
        end
    endtask

    task automatic test_overrun();
        int cyc;
        int w;
        ch_playing = 8'b0000_1000;
        ch_addr[32*3 +: 32] = 32'h3000;
        rsp_en = 1'b0;
        clear_logs();
        pulse_tick();
        w = 0;
        while (req_log.size() == 0 && w < 50) begin @(negedge clk); w++; end
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        n_vec++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set: got overrun %b busy %b required 1 1", overrun, busy);
        end
        late_rsp = 1'b1;
        wait_idle("ovr", cyc);
        rsp_en = 1'b1;
        n_vec++;
        if (req_log.size() != 1 || rdy_vec_log.size() != 1) begin
            n_fail++;
            $display("FAIL ovr_no_restart: got %0d requests %0d deliveries required 1 1", req_log.size(), rdy_vec_log.size());
        end else if (rdy_vec_log[0] !== 8'b0000_1000 || rdy_smp_log[0] !== rsp_log[0]) begin
            n_fail++;
            $display("FAIL ovr_deliver: got %b/%h required 00001000/%h", rdy_vec_log[0], rdy_smp_log[0], rsp_log[0]);
        end
        n_vec++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_sticky: got %b required 1", overrun);
        end
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        n_vec++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear: got %b required 0", overrun);
        end
        clear_logs();
        pulse_tick();
        sample_tick = 1'b1;
        overrun_clr = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        overrun_clr = 1'b0;
        n_vec++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set_wins: got %b required 1", overrun);
        end
        wait_idle("ovr2", cyc);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        int w;
        ch_playing = 8'b0000_1000;
        ch_addr[32*3 +: 32] = 32'h3000;
        rsp_en = 1'b0;
        clear_logs();
        pulse_tick();
        w = 0;
        while (req_log.size() == 0 && w < 50) begin @(negedge clk); w++; end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || mem_if.mem_req_valid !== 1'b0 || ch_ready !== '0 ||
            overrun !== 1'b0 || ch_sample !== 16'h0 || mem_if.mem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got busy %b valid %b ready %b ovr %b smp %h addr %h required all 0",
                     busy, mem_if.mem_req_valid, ch_ready, overrun, ch_sample, mem_if.mem_req_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        late_rsp = 1'b1;
        repeat (6) @(negedge clk);
        rsp_en = 1'b1;
        n_vec++;
        if (rdy_vec_log.size() != 0 || busy !== 1'b0 || ch_sample !== 16'h0) begin
            n_fail++;
            $display("FAIL midreset_late_rsp: got %0d deliveries busy %b smp %h required 0 0 0000",
                     rdy_vec_log.size(), busy, ch_sample);
        end
    endtask

`ifdef AUDIO_FETCH_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        ch_playing = 8'b0000_0110;
        for (int i = 0; i < NCH; i++) ch_addr[32*i +: 32] = $urandom;
        rsp_en = 1'b0;
        clear_logs();
        pulse_tick();
        wait_idle("timeout", cyc);
        rsp_en = 1'b1;
        check_round("timeout", ch_playing, ch_addr, cyc, 1'b1);
        n_vec++;
        if (to_cnt != 2 || to_rdy != 2) begin
            n_fail++;
            $display("FAIL timeout_pulses: got %0d pulses %0d with ready required 2 2", to_cnt, to_rdy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_no_channel();
        test_backpressure();
        test_overrun();
        test_reset_mid();
`ifdef AUDIO_FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
